// File: rtl/clk_div_gen.sv
// Multi-channel clock divider: each channel produces a registered divided clock
// level and a start-of-period tick, with reconfiguration deferred to a period boundary.
module clk_div_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic              cfg_err,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [CNT_W-1:0] period_q   [NUM_CH];
    logic [CNT_W-1:0] period_d   [NUM_CH];
    logic [CNT_W-1:0] high_q     [NUM_CH];
    logic [CNT_W-1:0] high_d     [NUM_CH];
    logic [CNT_W-1:0] phase_q    [NUM_CH];
    logic [CNT_W-1:0] phase_d    [NUM_CH];
    logic [CNT_W-1:0] cnt_q      [NUM_CH];
    logic [CNT_W-1:0] cnt_d      [NUM_CH];
    logic [CNT_W-1:0] shPeriod_q [NUM_CH];
    logic [CNT_W-1:0] shPeriod_d [NUM_CH];
    logic [CNT_W-1:0] shHigh_q   [NUM_CH];
    logic [CNT_W-1:0] shHigh_d   [NUM_CH];
    logic [CNT_W-1:0] shPhase_q  [NUM_CH];
    logic [CNT_W-1:0] shPhase_d  [NUM_CH];
    logic [CNT_W-1:0] highEff    [NUM_CH];

    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] clkOut_q, clkOut_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] chSel, wrEn, wrapHit, applyEn;

    logic cfgErr_q, cfgErr_d;
    logic cfgLegal, cfgAccept, cfgReady;

    assign cfgLegal = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) &&
                      (cfg_high < cfg_period) && (cfg_phase < cfg_period);

    // Out-of-range channel numbers are accepted and dropped so the port never stalls.
    always_comb begin
        chSel    = '0;
        cfgReady = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                chSel[i] = 1'b1;
                cfgReady = !pending_q[i];
            end
        end
    end

    assign cfgAccept = cfg_valid && cfgReady;
    assign cfgErr_d  = cfgAccept && !cfgLegal;
    assign cfg_ready = cfgReady;
    assign cfg_err   = cfgErr_q;
    assign clk_out   = clkOut_q;
    assign tick      = tick_q;

    always_comb begin
        wrEn    = '0;
        wrapHit = '0;
        applyEn = '0;
        en_d      = en_q;
        pending_d = pending_q;
        clkOut_d  = clkOut_q;
        tick_d    = tick_q;
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i]   = period_q[i];
            high_d[i]     = high_q[i];
            phase_d[i]    = phase_q[i];
            cnt_d[i]      = cnt_q[i];
            shPeriod_d[i] = shPeriod_q[i];
            shHigh_d[i]   = shHigh_q[i];
            shPhase_d[i]  = shPhase_q[i];
            highEff[i]    = high_q[i];

            wrEn[i]    = cfgAccept && cfgLegal && chSel[i];
            wrapHit[i] = en_q[i] && (cnt_q[i] == period_q[i] - CNT_W'(1));
            // A stopped channel has no boundary to wait for, so it takes the shadow at once.
            applyEn[i] = pending_q[i] && (!ch_en[i] || wrapHit[i]);

            if (applyEn[i]) begin
                period_d[i]  = shPeriod_q[i];
                high_d[i]    = shHigh_q[i];
                phase_d[i]   = shPhase_q[i];
                highEff[i]   = shHigh_q[i];
                pending_d[i] = 1'b0;
            end
            if (wrEn[i]) begin
                shPeriod_d[i] = cfg_period;
                shHigh_d[i]   = cfg_high;
                shPhase_d[i]  = cfg_phase;
                pending_d[i]  = 1'b1;
            end

            if (ch_en[i]) begin
                en_d[i] = 1'b1;
                if (!en_q[i]) begin
                    cnt_d[i] = phase_q[i];
                end else if (wrapHit[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                clkOut_d[i] = (cnt_d[i] < highEff[i]);
                tick_d[i]   = (cnt_d[i] == '0);
            end else begin
                en_d[i]     = 1'b0;
                cnt_d[i]    = '0;
                clkOut_d[i] = 1'b0;
                tick_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= '0;
            pending_q <= '0;
            clkOut_q  <= '0;
            tick_q    <= '0;
            cfgErr_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i]   <= CNT_W'(2);
                high_q[i]     <= CNT_W'(1);
                phase_q[i]    <= '0;
                cnt_q[i]      <= '0;
                shPeriod_q[i] <= CNT_W'(2);
                shHigh_q[i]   <= CNT_W'(1);
                shPhase_q[i]  <= '0;
            end
        end else begin
            en_q      <= en_d;
            pending_q <= pending_d;
            clkOut_q  <= clkOut_d;
            tick_q    <= tick_d;
            cfgErr_q  <= cfgErr_d;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i]   <= period_d[i];
                high_q[i]     <= high_d[i];
                phase_q[i]    <= phase_d[i];
                cnt_q[i]      <= cnt_d[i];
                shPeriod_q[i] <= shPeriod_d[i];
                shHigh_q[i]   <= shHigh_d[i];
                shPhase_q[i]  <= shPhase_d[i];
            end
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: directed stimulus queues per-cycle expected
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_clk_div_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;
    localparam int F_CLK  = 0;
    localparam int F_TICK = 1;
    localparam int F_RDY  = 2;
    localparam int F_ERR  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_phase;
    logic              cfg_err;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    typedef struct {
        int    cyc;
        int    field;
        int    ch;
        logic  val;
        string name;
    } exp_t;

    exp_t sbQ[$];
    exp_t monItem;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    clk_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_phase  (cfg_phase),
        .cfg_err    (cfg_err),
        .ch_en      (ch_en),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expectAt(input int c, input int field, input int ch, input logic val, input string name);
        exp_t e;
        int idx;
        e.cyc = c; e.field = field; e.ch = ch; e.val = val; e.name = name;
        idx = sbQ.size();
        for (int i = 0; i < sbQ.size(); i++) begin
            if (sbQ[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sbQ.insert(idx, e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic act;
        case (e.field)
            F_CLK:   act = clk_out[e.ch];
            F_TICK:  act = tick[e.ch];
            F_RDY:   act = cfg_ready;
            default: act = cfg_err;
        endcase
        vectors++;
        if (act !== e.val) begin
            miscompares++;
            $display("[TB] FAIL %s cyc=%0d ch=%0d got=%b expected=%b", e.name, e.cyc, e.ch, act, e.val);
        end
    endtask

    // Outputs are sampled mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
            monItem = sbQ.pop_front();
            if (monItem.cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL %s late entry cyc=%0d now=%0d", monItem.name, monItem.cyc, cyc);
            end else begin
                checkOutput(monItem);
            end
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) tick1();
    endtask

    // Drives one write for a single cycle; returns one cycle later with the port idle.
    task automatic applyStimulus(input int ch, input int p, input int h, input int ph);
        cfg_valid  = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
        cfg_phase  = CNT_W'(ph);
        tick1();
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
    endtask

    task automatic expectIdle(input int c, input int ch, input string name);
        expectAt(c, F_CLK, ch, 1'b0, name);
        expectAt(c, F_TICK, ch, 1'b0, name);
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e0, e1, p, e2, e4;
        int badP[4];
        int badH[4];
        int badPh[4];
        badP  = '{10, 10, 1, 10};
        badH  = '{0, 10, 1, 5};
        badPh = '{0, 0, 0, 10};

        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_period = '0; cfg_high = '0; cfg_phase = '0; ch_en = '0;
        tick1();
        tick1();
        for (int c = 0; c < NUM_CH; c++) expectIdle(cyc, c, "reset_out");
        expectAt(cyc, F_RDY, 0, 1'b1, "reset_ready");
        expectAt(cyc, F_ERR, 0, 1'b0, "reset_err");
        rst = 1'b0;

        // Basic divide on ch0, applied while disabled.
        applyStimulus(0, 10, 5, 0);
        expectAt(cyc, F_ERR, 0, 1'b0, "legal_no_err");
        expectAt(cyc, F_RDY, 0, 1'b0, "pending_ready");
        expectAt(cyc + 1, F_RDY, 0, 1'b1, "disabled_apply_ready");
        tick1();
        ch_en[0] = 1'b1;
        e0 = cyc + 1;
        for (int t = 0; t < 20; t++) begin
            expectAt(e0 + t, F_CLK, 0, (t % 10) < 5, "div10_clk");
            expectAt(e0 + t, F_TICK, 0, (t % 10) == 0, "div10_tick");
        end
        for (int t = 0; t < 16; t++) begin
            expectAt(e0 + 20 + t, F_CLK, 0, (t % 4) == 0, "reconf4_clk");
            expectAt(e0 + 20 + t, F_TICK, 0, (t % 4) == 0, "reconf4_tick");
        end

        // Reconfigure mid-period at cnt=3, then try a second write while pending.
        waitUntil(e0 + 13);
        applyStimulus(0, 4, 1, 0);
        expectAt(cyc, F_ERR, 0, 1'b0, "reconf_no_err");
        expectAt(e0 + 15, F_RDY, 0, 1'b0, "busy_ready");
        waitUntil(e0 + 15);
        applyStimulus(0, 6, 3, 0);
        expectAt(cyc, F_ERR, 0, 1'b0, "rejected_no_err");

        // Odd period on ch1 while ch0 waits for its wrap.
        applyStimulus(1, 7, 2, 0);
        expectAt(cyc, F_ERR, 0, 1'b0, "ch1_no_err");
        expectAt(e0 + 17, F_RDY, 0, 1'b0, "still_pending");
        expectAt(e0 + 19, F_RDY, 0, 1'b0, "pending_before_wrap");
        expectAt(e0 + 20, F_RDY, 0, 1'b1, "pending_cleared_wrap");
        waitUntil(e0 + 18);
        ch_en[1] = 1'b1;
        e1 = cyc + 1;
        for (int t = 0; t < 21; t++) begin
            expectAt(e1 + t, F_CLK, 1, (t % 7) < 2, "div7_clk");
            expectAt(e1 + t, F_TICK, 1, (t % 7) == 0, "div7_tick");
        end

        // Phase offset: stop both, reprogram, start on the same edge.
        p = e0 + 40;
        waitUntil(p);
        ch_en[1:0] = 2'b00;
        expectIdle(p + 1, 0, "stop_ch0");
        expectIdle(p + 1, 1, "stop_ch1");
        tick1();
        applyStimulus(0, 10, 5, 0);
        applyStimulus(1, 10, 5, 5);
        tick1();
        ch_en[1:0] = 2'b11;
        e2 = cyc + 1;
        for (int t = 0; t < 22; t++) begin
            expectAt(e2 + t, F_CLK, 0, (t % 10) < 5, "phase0_clk");
            expectAt(e2 + t, F_TICK, 0, (t % 10) == 0, "phase0_tick");
        end
        for (int t = 22; t < 25; t++) expectIdle(e2 + t, 0, "disabled_ch0");
        for (int t = 0; t < 25; t++) begin
            expectAt(e2 + t, F_CLK, 1, !((t % 10) < 5), "phase5_clk");
            expectAt(e2 + t, F_TICK, 1, (t % 10) == 5, "phase5_tick");
        end

        // ch3 runs from reset defaults (period 2, high 1).
        waitUntil(e2 + 2);
        ch_en[3] = 1'b1;
        for (int t = 0; t < 22; t++) begin
            expectAt(e2 + 3 + t, F_CLK, 3, (t % 2) == 0, "default_clk");
            expectAt(e2 + 3 + t, F_TICK, 3, (t % 2) == 0, "default_tick");
        end

        // Illegal writes to running ch0: each must pulse cfg_err exactly once.
        for (int k = 0; k < 4; k++) begin
            waitUntil(e2 + 3 + 2 * k);
            expectAt(e2 + 4 + 2 * k, F_ERR, 0, 1'b1, "illegal_err");
            expectAt(e2 + 5 + 2 * k, F_ERR, 0, 1'b0, "illegal_err_once");
            applyStimulus(0, badP[k], badH[k], badPh[k]);
        end
        expectAt(e2 + 11, F_RDY, 0, 1'b1, "illegal_not_pending");

        // Drop ch0 mid-high, leave a write pending on ch1, then reset.
        waitUntil(e2 + 21);
        ch_en[0] = 1'b0;
        waitUntil(e2 + 22);
        applyStimulus(1, 10, 3, 0);
        expectAt(cyc, F_ERR, 0, 1'b0, "ch1_pend_no_err");
        waitUntil(e2 + 24);
        cfg_ch = 2'd1;
        expectAt(cyc, F_RDY, 1, 1'b0, "ch1_pending_ready");
        rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) expectIdle(e2 + 25, c, "midrun_reset_out");
        expectAt(e2 + 25, F_RDY, 1, 1'b1, "midrun_reset_ready");
        expectAt(e2 + 25, F_ERR, 0, 1'b0, "midrun_reset_err");
        tick1();
        rst = 1'b0;
        e4 = cyc + 1;
        for (int t = 0; t < 6; t++) begin
            expectAt(e4 + t, F_CLK, 1, (t % 2) == 0, "post_reset_ch1_clk");
            expectAt(e4 + t, F_TICK, 1, (t % 2) == 0, "post_reset_ch1_tick");
            expectAt(e4 + t, F_CLK, 3, (t % 2) == 0, "post_reset_ch3_clk");
            expectIdle(e4 + t, 0, "post_reset_ch0");
        end
        expectAt(e4 + 1, F_RDY, 1, 1'b1, "post_reset_ready");

        waitUntil(e4 + 8);
        while (sbQ.size() > 0) begin
            monItem = sbQ.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s never checked cyc=%0d", monItem.name, monItem.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Synthesizable multi-channel clock-divider/generator. It derives NUM_CH independent divided clock-level outputs and one-cycle tick strobes from the single system clock. Each channel has a runtime-programmable period, high time and start phase. Configuration changes are applied only at a period boundary, so a running output never sees a runt pulse from reconfiguration. The block sits next to the system clock root and feeds peripherals that need slower rates; for example, a 100 MHz clk with period 10 gives a 10 MHz output.

## Interface
Parameters:
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 16: width of the period, high and phase counters and fields.
- CH_W, $clog2(NUM_CH) (min 1): width of cfg_ch.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready; equals !pending[cfg_ch].
- cfg_ch  in  CH_W  target channel.
- cfg_period  in  CNT_W  period in clk cycles; legal range 2..2^CNT_W-1.
- cfg_high  in  CNT_W  high time in cycles; legal range 1..cfg_period-1.
- cfg_phase  in  CNT_W  counter start value on enable; legal range 0..cfg_period-1.
- cfg_err  out  1  one-cycle pulse when an accepted write is illegal.
- ch_en  in  NUM_CH  per-channel run enable.
- clk_out  out  NUM_CH  divided clock level, registered.
- tick  out  NUM_CH  one-cycle pulse at the start of each period (cnt==0), registered.

## Operation
Per-channel active registers:
- period, high, phase, cnt, en_q.

Per-channel shadow registers:
- s_period, s_high, s_phase, plus a pending flag.

Configuration:
- An accepted write is checked for legality: period>=2, 1<=high<period, phase<period.
- An illegal write pulses cfg_err on the next cycle and changes no state. It is still accepted (cfg_ready is not dropped).
- A legal write loads the shadow registers and sets pending.
- A pending channel holds cfg_ready low whenever cfg_ch selects it.

Apply:
- Running channel: shadow is copied to active on the edge where cnt==period-1 (wrap). pending clears on that same edge.
- Disabled channel (ch_en=0): shadow is applied on the edge after acceptance.
- A write accepted on the same edge as a wrap is not applied at that wrap. It applies at the following wrap.

Run (edge with ch_en=1):
- Enable rising (en_q=0): cnt <= phase.
- Otherwise: cnt <= (cnt==period-1) ? 0 : cnt+1, using the new period/high on an apply edge.
- Every run edge: clk_out <= (cnt_next < high); tick <= (cnt_next == 0).

Disable:
- Edge with ch_en=0: cnt<=0, clk_out<=0, tick<=0.
- Disable is immediate, so a truncated high phase is allowed.
- phase takes effect only on an enable rising edge, never at a wrap.

Channels share only the config port. All else is independent.

## Timing
- Reset values:
  - active and shadow: period=2, high=1, phase=0.
  - cnt=0, en_q=0, pending=0, clk_out=0, tick=0, cfg_err=0.
  - cfg_ready=1.
- rst asserted mid-operation returns everything to reset values on that edge. Pending writes are lost.
- Enable latency: ch_en sampled high at edge E gives clk_out/tick reflecting cnt=phase after E. With phase=0, tick=1 and clk_out=1 in the cycle after E.
- Steady state: clk_out is high for exactly `high` cycles and low for `period-high` cycles. tick fires every `period` cycles, in the first cycle of the high phase.
- Apply latency: between 1 and period cycles after acceptance, always on a wrap edge. The first period after apply is full-length with the new values.
- cfg_err: asserted exactly one cycle, on the edge after the illegal accept.
- Counter arithmetic is CNT_W-bit unsigned. cnt never exceeds period-1, so no overflow is possible.

## Test plan
- Basic divide: ch0 period=10, high=5, phase=0, enable. Required: clk_out shows 5 high/5 low repeating, tick every 10 cycles, first tick one cycle after enable.
- Duty/odd period: ch1 period=7, high=2. Required: 2 high/5 low; tick coincides with each rising clk_out.
- Glitch-free reconfig: ch0 running at 10/5; at cnt=3, write period=4, high=1. Required:
  - current period completes at 10/5.
  - then 1 high/3 low.
  - a second write before the apply sees cfg_ready=0.
  - pending clears on the wrap edge.
- Phase offset: ch0 and ch1 both 10/5, phase 0 and 5, enabled on the same edge. Required: ch1 clk_out is the inverse of ch0; ch1 tick lags ch0 tick by 5 cycles.
- Illegal configs: high=0; high=period; period=1; phase=period. Required: cfg_err pulses once each, active values unchanged, output undisturbed.
- Disable/reset mid-run: drop ch_en in the middle of the high phase, then assert rst while other channels run. Required:
  - the disabled channel's clk_out is 0 on the next edge.
  - after rst, all outputs take reset values and cfg_ready=1.
